// File: rtl/cmd_decoder_pkg.sv
// rtl/cmd_decoder_pkg.sv - shared command ids, default sizes and VLQ helpers
package cmd_decoder_pkg;

  localparam int CMD_BITS_DEFAULT = 8;
  localparam int MAX_ARGS_DEFAULT = 8;

  localparam int CMD_SET_DIGITAL_OUT      = 1;
  localparam int CMD_CONFIG_DIGITAL_OUT   = 2;
  localparam int CMD_SCHEDULE_DIGITAL_OUT = 3;
  localparam int CMD_UPDATE_DIGITAL_OUT   = 4;

  // A leading byte with bits 6:5 both set starts a negative value.
  function automatic logic [31:0] vlq_first(input logic [7:0] c);
    logic [31:0] v;
    v = {25'd0, c[6:0]};
    if (c[6:5] == 2'b11) v = v | 32'hFFFF_FFE0;
    return v;
  endfunction

  function automatic logic [31:0] vlq_next(input logic [31:0] acc, input logic [7:0] c);
    return {acc[24:0], c[6:0]};
  endfunction

endpackage

// File: rtl/cmd_decoder_vlq_accum.sv
// rtl/cmd_decoder_vlq_accum.sv - byte-serial VLQ accumulator; value is valid with done
module vlq_accum
  import cmd_decoder_pkg::*;
(
  input  logic        clk,
  input  logic [7:0]  data,
  input  logic        strobe,
  input  logic        clear,
  output logic [31:0] value,
  output logic        done
);

  logic [31:0] acc;
  logic        first;

  assign value = first ? vlq_first(data) : vlq_next(acc, data);
  assign done  = strobe && !data[7];

  always_ff @(posedge clk) begin
    if (clear) begin
      acc   <= '0;
      first <= 1'b1;
    end else if (strobe) begin
      acc   <= value;
      first <= !data[7];
    end
  end

endmodule

// File: rtl/cmd_decoder.sv
// rtl/cmd_decoder.sv - decodes one framed message into a command id plus argument buffer
module cmd_decoder
  import cmd_decoder_pkg::*;
#(
  parameter int CMD_BITS = CMD_BITS_DEFAULT,
  parameter int MAX_ARGS = MAX_ARGS_DEFAULT
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [7:0]          msg_data,
  input  logic                msg_valid,
  input  logic                msg_end,
  output logic                msg_ready,
  output logic [CMD_BITS-1:0] cmd,
  output logic                cmd_ready,
  input  logic                cmd_done,
  output logic [31:0]         arg_data,
  input  logic                arg_advance,
  output logic                err_overflow,
  output logic                err_truncated
);

  typedef enum logic [2:0] {S_IDLE, S_CMDID, S_ARGS, S_ISSUE, S_WAIT, S_DRAIN} state_t;

  localparam int PW = $clog2(MAX_ARGS + 1);
  localparam int IW = $clog2(MAX_ARGS);
  localparam logic [PW-1:0] ARG_LIMIT = PW'(MAX_ARGS);

  state_t        state, state_next;
  logic          accept, decoding, truncated, id_bad;
  logic [31:0]   value;
  logic          value_done;
  logic          set_cmd, store_arg, start_msg, overflow_next, truncated_next;
  logic [PW-1:0] n, p;
  logic [31:0]   argbuf [MAX_ARGS];

  assign msg_ready = !rst && (state inside {S_IDLE, S_CMDID, S_ARGS, S_DRAIN});
  assign accept    = msg_valid && msg_ready;
  assign decoding  = state inside {S_IDLE, S_CMDID, S_ARGS};
  assign truncated = accept && msg_end && msg_data[7];
  assign id_bad    = |(value >> CMD_BITS);
  assign cmd_ready = (state == S_ISSUE);
  assign arg_data  = (p < n) ? argbuf[p[IW-1:0]] : '0;

  vlq_accum u_vlq (
    .clk    (clk),
    .data   (msg_data),
    .strobe (accept && decoding),
    .clear  (rst || truncated),
    .value  (value),
    .done   (value_done)
  );

  always_comb begin
    state_next     = state;
    set_cmd        = 1'b0;
    store_arg      = 1'b0;
    start_msg      = 1'b0;
    overflow_next  = 1'b0;
    truncated_next = 1'b0;
    case (state)
      S_IDLE, S_CMDID, S_ARGS, S_DRAIN: begin
        if (accept) begin
          if (state == S_IDLE) begin
            start_msg  = 1'b1;
            state_next = S_CMDID;
          end
          if (truncated) begin
            truncated_next = 1'b1;
            state_next     = S_IDLE;
          end else if (state == S_DRAIN) begin
            if (msg_end) state_next = S_IDLE;
          end else if (value_done) begin
            // The first value is the id; every later one needs a free buffer slot.
            if ((state == S_ARGS) ? (n == ARG_LIMIT) : id_bad) begin
              overflow_next = 1'b1;
              state_next    = msg_end ? S_IDLE : S_DRAIN;
            end else begin
              set_cmd    = (state != S_ARGS);
              store_arg  = (state == S_ARGS);
              state_next = msg_end ? S_ISSUE : S_ARGS;
            end
          end
        end
      end
      S_ISSUE: state_next = S_WAIT;
      S_WAIT:  if (cmd_done) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cmd           <= '0;
      n             <= '0;
      p             <= '0;
      err_overflow  <= 1'b0;
      err_truncated <= 1'b0;
    end else begin
      err_overflow  <= overflow_next;
      err_truncated <= truncated_next;
      if (set_cmd) cmd <= value[CMD_BITS-1:0];
      if (start_msg)      n <= '0;
      else if (store_arg) n <= n + PW'(1);
      if (state != S_ISSUE && state_next == S_ISSUE)
        p <= '0;
      else if ((state == S_ISSUE || state == S_WAIT) && arg_advance && p != ARG_LIMIT)
        p <= p + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (store_arg) argbuf[n[IW-1:0]] <= value;
  end

endmodule

// File: tb/tb_cmd_decoder.sv
// tb/tb_cmd_decoder.sv - randomized message stream checked against a message-level model
module tb_cmd_decoder;

  localparam int MAXA    = 8;
  localparam int K_NONE  = 0;
  localparam int K_ISSUE = 1;
  localparam int K_OVF   = 2;
  localparam int K_TRUNC = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  msg_data = '0;
  logic        msg_valid = 1'b0;
  logic        msg_end = 1'b0;
  logic        msg_ready;
  logic [7:0]  cmd;
  logic        cmd_ready;
  logic        cmd_done = 1'b0;
  logic [31:0] arg_data;
  logic        arg_advance = 1'b1;
  logic        err_overflow;
  logic        err_truncated;

  always #5 clk = ~clk;

  cmd_decoder #(.CMD_BITS(8), .MAX_ARGS(MAXA)) dut (
    .clk           (clk),
    .rst           (rst),
    .msg_data      (msg_data),
    .msg_valid     (msg_valid),
    .msg_end       (msg_end),
    .msg_ready     (msg_ready),
    .cmd           (cmd),
    .cmd_ready     (cmd_ready),
    .cmd_done      (cmd_done),
    .arg_data      (arg_data),
    .arg_advance   (arg_advance),
    .err_overflow  (err_overflow),
    .err_truncated (err_truncated)
  );

  int          total = 0;
  int          bad = 0;
  logic [7:0]  cur_msg[$];
  logic [7:0]  stim_data[$];
  bit          stim_end[$];
  int          exp_kind[$];
  logic [31:0] exp_cmd[$];
  logic [31:0] exp_args[$];
  logic [31:0] cur_args [MAXA+1];
  bit          waiting = 0, after_done = 0, auto_done = 1, spurious = 0, rand_delay = 0;
  int          cap_k = 99;
  int          cons_delay = 20;
  int          gap_pct = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // Shortest VLQ byte string whose decode gives v back.
  task automatic enc(input logic [31:0] v);
    longint sv, lo, hi;
    int k;
    logic [7:0] b;
    sv = {{32{v[31]}}, v};
    k = 5;
    for (int j = 5; j >= 1; j--) begin
      lo = -(longint'(32) << (7 * (j - 1)));
      hi = (longint'(96) << (7 * (j - 1))) - 1;
      if (sv >= lo && sv <= hi) k = j;
    end
    for (int i = 0; i < k; i++) begin
      b = 8'((sv >>> (7 * (k - 1 - i))) & 64'h7F);
      if (i < k - 1) b = b | 8'h80;
      cur_msg.push_back(b);
    end
  endtask

  // Decode a whole message into values and predict the visible outcome.
  task automatic model_msg();
    logic [31:0] v, vals[$];
    logic [7:0]  c;
    bit start, dead, ovf, trunc;
    v = 0; start = 1; dead = 0; ovf = 0;
    foreach (cur_msg[i]) begin
      c = cur_msg[i];
      stim_data.push_back(c);
      stim_end.push_back(i == cur_msg.size() - 1);
      if (!dead) begin
        if (start) begin
          v = 32'(c & 8'h7F);
          if ((c & 8'h60) == 8'h60) v = v | 32'hFFFF_FFE0;
        end else begin
          v = (v << 7) | 32'(c & 8'h7F);
        end
        start = (c < 8'h80);
        if (start) begin
          if ((vals.size() == 0 && v > 255) || vals.size() == MAXA + 1) begin
            ovf = 1; dead = 1;
          end else begin
            vals.push_back(v);
          end
        end
      end
    end
    trunc = cur_msg[cur_msg.size() - 1] >= 8'h80;
    if (ovf) begin
      exp_kind.push_back(K_OVF); exp_cmd.push_back(0);
      for (int k = 0; k <= MAXA; k++) exp_args.push_back(0);
    end
    if (trunc) begin
      exp_kind.push_back(K_TRUNC); exp_cmd.push_back(0);
      for (int k = 0; k <= MAXA; k++) exp_args.push_back(0);
    end
    if (!ovf && !trunc) begin
      exp_kind.push_back(K_ISSUE); exp_cmd.push_back(vals[0]);
      for (int k = 0; k <= MAXA; k++) exp_args.push_back((k + 1 < vals.size()) ? vals[k + 1] : 32'd0);
    end
  endtask

  function automatic logic [31:0] rand_val();
    case ($urandom_range(0, 3))
      0:       return 32'($urandom_range(0, 200));
      1:       return 32'(-$urandom_range(1, 5000));
      2:       return $urandom;
      default: return 32'd1 << $urandom_range(0, 31);
    endcase
  endfunction

  task automatic gen_random();
    int na;
    cur_msg.delete();
    if ($urandom_range(0, 9) == 0) begin
      na = $urandom_range(1, 6);
      for (int i = 0; i < na; i++) cur_msg.push_back(8'($urandom));
    end else begin
      if ($urandom_range(0, 9) == 0) enc(32'(256 + $urandom_range(0, 5000)));
      else enc(32'($urandom_range(0, 255)));
      na = $urandom_range(0, MAXA + 1);
      for (int i = 0; i < na; i++) enc(rand_val());
      if ($urandom_range(0, 7) == 0) cur_msg.push_back(8'h80 | 8'($urandom_range(0, 127)));
    end
    model_msg();
  endtask

  task automatic expect_event(input int kind);
    int k;
    logic [31:0] c;
    if (exp_kind.size() == 0) begin
      check_eq("unexpected_event", kind, K_NONE);
      return;
    end
    k = exp_kind.pop_front();
    c = exp_cmd.pop_front();
    for (int i = 0; i <= MAXA; i++) cur_args[i] = exp_args.pop_front();
    check_eq("event_kind", kind, k);
    if (kind == K_ISSUE) check_eq("cmd", 32'(cmd), c);
  endtask

  always @(negedge clk) begin
    if (rst) begin
      waiting = 0; after_done = 0; cap_k = 99;
    end else begin
      if (after_done) begin
        check_eq("ready_after_done", 32'(msg_ready), 1);
        after_done = 0;
      end
      if (cap_k <= MAXA) begin
        check_eq($sformatf("arg%0d", cap_k), arg_data, cur_args[cap_k]);
        cap_k++;
      end
      if (err_overflow) expect_event(K_OVF);
      if (err_truncated) expect_event(K_TRUNC);
      if (cmd_ready) begin
        expect_event(K_ISSUE);
        check_eq("arg0", arg_data, cur_args[0]);
        cap_k = 1;
        waiting = 1;
      end
      if (waiting) begin
        check_eq("hold_off", 32'(msg_ready), 0);
        if (cmd_done) begin
          waiting = 0; after_done = 1;
        end
      end
    end
  end

  initial begin
    int d;
    forever begin
      @(posedge clk); #1;
      if (auto_done && cmd_ready) begin
        cmd_done = 1'b0;
        d = rand_delay ? $urandom_range(9, 25) : cons_delay;
        repeat (d) @(posedge clk);
        #1 cmd_done = 1'b1;
        @(posedge clk);
        #1 cmd_done = 1'b0;
      end else begin
        cmd_done = spurious && ($urandom_range(0, 7) == 0);
      end
    end
  end

  task automatic drive_all();
    int idx = 0, stall = 0;
    while (idx < stim_data.size()) begin
      @(posedge clk); #1;
      msg_valid = ($urandom_range(0, 99) >= gap_pct);
      msg_data  = stim_data[idx];
      msg_end   = stim_end[idx];
      if (msg_valid && msg_ready) begin
        idx++; stall = 0;
      end else begin
        stall++;
        if (stall > 300) begin
          check_eq("drive_stall", stall, 0);
          break;
        end
      end
    end
    @(posedge clk); #1;
    msg_valid = 1'b0; msg_end = 1'b0;
    stim_data.delete(); stim_end.delete();
  endtask

  task automatic wait_drained();
    int t = 0;
    while (exp_kind.size() != 0 && t < 3000) begin
      @(negedge clk); t++;
    end
    check_eq("events_drained", exp_kind.size(), 0);
    repeat (40) @(negedge clk);
  endtask

  task automatic check_reset_values(input string tag);
    check_eq({tag, "_cmd"}, 32'(cmd), 0);
    check_eq({tag, "_cmd_ready"}, 32'(cmd_ready), 0);
    check_eq({tag, "_arg_data"}, arg_data, 0);
    check_eq({tag, "_err_ovf"}, 32'(err_overflow), 0);
    check_eq({tag, "_err_trunc"}, 32'(err_truncated), 0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check_eq("rst_msg_ready", 32'(msg_ready), 0);
    check_reset_values("rst");
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check_eq("post_rst_msg_ready", 32'(msg_ready), 1);

    // directed messages, consumer holds WAIT for 20 cycles
    cur_msg = '{8'h02, 8'h03, 8'h01, 8'h00, 8'h87, 8'h68}; model_msg();
    cur_msg = '{8'h04, 8'h7F, 8'h80, 8'h60};               model_msg();
    cur_msg = '{8'h02, 8'h03, 8'h01, 8'h00, 8'h87, 8'h68}; model_msg();
    cur_msg = '{8'h01, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09}; model_msg();
    cur_msg = '{8'h04, 8'h05};                             model_msg();
    cur_msg = '{8'h03, 8'h85};                             model_msg();
    cur_msg = '{8'h82, 8'h00, 8'h05, 8'h06};               model_msg();
    cur_msg = '{8'h01, 8'h7F, 8'h81, 8'h00};               model_msg();
    drive_all();
    wait_drained();

    // random messages with input gaps, random WAIT length, stray cmd_done
    rand_delay = 1; spurious = 1; gap_pct = 25;
    for (int m = 0; m < 120; m++) gen_random();
    drive_all();
    wait_drained();
    spurious = 0; gap_pct = 0;

    // reset while waiting for cmd_done
    auto_done = 0;
    cur_msg = '{8'h01, 8'h05}; model_msg();
    drive_all();
    wait_drained();
    check_eq("wait_cmd_held", 32'(cmd), 1);
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    check_eq("wait_rst_msg_ready", 32'(msg_ready), 0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check_reset_values("wait_rst");
    check_eq("wait_rst_msg_ready_after", 32'(msg_ready), 1);
    auto_done = 1;
    cur_msg = '{8'h02, 8'h03, 8'h01, 8'h00, 8'h87, 8'h68}; model_msg();
    drive_all();
    wait_drained();

    // reset in the middle of an argument
    stim_data = '{8'h03, 8'h05, 8'h83};
    stim_end  = '{1'b0, 1'b0, 1'b0};
    drive_all();
    rst = 1'b1;
    @(negedge clk);
    check_eq("args_rst_msg_ready", 32'(msg_ready), 0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check_reset_values("args_rst");
    check_eq("args_rst_msg_ready_after", 32'(msg_ready), 1);
    cur_msg = '{8'h04, 8'h7F, 8'h80, 8'h60}; model_msg();
    drive_all();
    wait_drained();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
